// File: rtl/pool_stream_unit.sv
// Streaming multi-lane pooling engine: every POOL_SIZE accepted beats are reduced per lane
// to one signed max or floor-average result, held in a single output register.
module pool_stream_unit #(
  parameter int IN_W      = 20,
  parameter int OUT_W     = 20,
  parameter int LANES     = 4,
  parameter int POOL_SIZE = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode_i,
  input  logic                         clr_i,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*IN_W-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*OUT_W-1:0]       out_data,
  output logic [$clog2(POOL_SIZE)-1:0] win_cnt_o
);
  localparam int CNT_W = $clog2(POOL_SIZE);
  localparam int ACC_W = IN_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(POOL_SIZE - 1);

  typedef enum logic {EMPTY, ACCUM} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic                    accept, first_beat, last_beat;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*OUT_W-1:0]  out_data_q, out_data_d;

  logic signed [ACC_W-1:0] acc_q   [LANES];
  logic signed [ACC_W-1:0] acc_d   [LANES];
  logic signed [ACC_W-1:0] acc_nxt [LANES];
  logic signed [ACC_W-1:0] in_ext  [LANES];
  logic signed [IN_W-1:0]  res_lane[LANES];

  // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end else if (accept) begin
      if (last_beat) begin
        state_d = EMPTY;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // A single output register: a held, undrained result blocks new beats.
  always_comb begin
    in_ready   = !out_valid_q || out_ready;
    accept     = in_valid && in_ready && !clr_i;
    first_beat = accept && (state_q == EMPTY);
    last_beat  = accept && (cnt_q == LAST_CNT);
  end

  always_comb begin
    mode_d      = first_beat ? mode_i : mode_q;
    out_data_d  = out_data_q;
    out_valid_d = last_beat || (out_valid_q && !out_ready);
    for (int k = 0; k < LANES; k++) begin
      in_ext[k] = ACC_W'($signed(in_data[k*IN_W +: IN_W]));
      if (first_beat)
        acc_nxt[k] = in_ext[k];
      else if (mode_q)
        acc_nxt[k] = acc_q[k] + in_ext[k];
      else
        acc_nxt[k] = (in_ext[k] > acc_q[k]) ? in_ext[k] : acc_q[k];
      // Mode is always the latched one here: the last beat can never be the first.
      res_lane[k] = IN_W'(mode_q ? (acc_nxt[k] >>> CNT_W) : acc_nxt[k]);
      acc_d[k]    = clr_i ? '0 : (accept ? acc_nxt[k] : acc_q[k]);
      if (last_beat)
        out_data_d[k*OUT_W +: OUT_W] = OUT_W'(res_lane[k]);
    end
  end

  // NOTE: the accumulator array is a handful of flops, not a RAM, so it is reset with the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
    end else begin
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int k = 0; k < LANES; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign win_cnt_o = cnt_q;

endmodule

// File: tb/tb_pool_stream_unit.sv
// Directed bench for pool_stream_unit (4 lanes x 20 bits, windows of 4 beats);
// expected results are hand-computed per scenario.
module tb_pool_stream_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mode_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [79:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [79:0] out_data;
  logic [1:0]  win_cnt_o;

  int tests_run    = 0;
  int tests_failed = 0;

  pool_stream_unit #(.IN_W(20), .OUT_W(20), .LANES(4), .POOL_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .clr_i(clr_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .win_cnt_o(win_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] pk(input int a, input int b, input int c, input int d);
    return {20'(d), 20'(c), 20'(b), 20'(a)};
  endfunction

  // One beat presented for one edge; callers ensure in_ready is high.
  task automatic send(input logic m, input logic [79:0] d);
    mode_i   = m;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests_run++; if (out_data !== 80'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", out_data); end
    tests_run++; if (win_cnt_o !== 2'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", win_cnt_o); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_max();
    out_ready = 1'b1;
    send(1'b0, pk(5, -8, 100, 0));
    send(1'b0, pk(-3, -1, -100, 0));
    tests_run++; if (win_cnt_o !== 2'd2) begin tests_failed++; $display("FAIL max_cnt2: got %0d want 2", win_cnt_o); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL max_early_valid: got %b want 0", out_valid); end
    send(1'b0, pk(17, -20, 7, 0));
    send(1'b0, pk(2, -9, -5, 0));
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL max_valid: got %b want 1", out_valid); end
    tests_run++; if (out_data !== pk(17, -1, 100, 0)) begin tests_failed++; $display("FAIL max_data: got %h want %h", out_data, pk(17, -1, 100, 0)); end
    tests_run++; if (win_cnt_o !== 2'd0) begin tests_failed++; $display("FAIL max_cnt_wrap: got %0d want 0", win_cnt_o); end
    idle_cycle();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL max_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_avg();
    send(1'b1, pk(3, -1, 10, -7));
    send(1'b1, pk(4, -1, 10, 0));
    send(1'b1, pk(5, -1, 10, 0));
    send(1'b1, pk(6, -2, 9, 0));
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL avg_valid: got %b want 1", out_valid); end
    tests_run++; if (out_data !== pk(4, -2, 9, -2)) begin tests_failed++; $display("FAIL avg_data: got %h want %h", out_data, pk(4, -2, 9, -2)); end
    idle_cycle();
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 4; i++) send(1'b1, pk(524287, 524287, 524287, 524287));
    tests_run++; if (out_data !== pk(524287, 524287, 524287, 524287)) begin tests_failed++; $display("FAIL ext_avg_pos: got %h want %h", out_data, pk(524287, 524287, 524287, 524287)); end
    for (int i = 0; i < 4; i++) send(1'b1, pk(-524288, -524288, -524288, -524288));
    tests_run++; if (out_data !== pk(-524288, -524288, -524288, -524288)) begin tests_failed++; $display("FAIL ext_avg_neg: got %h want %h", out_data, pk(-524288, -524288, -524288, -524288)); end
    send(1'b0, pk(524287, -524288, -524288, 0));
    send(1'b0, pk(-524288, -524288, 524287, -1));
    send(1'b0, pk(0, -524288, 0, -1));
    send(1'b0, pk(1, -524288, 0, -1));
    tests_run++; if (out_data !== pk(524287, -524288, 524287, 0)) begin tests_failed++; $display("FAIL ext_max: got %h want %h", out_data, pk(524287, -524288, 524287, 0)); end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(1'b0, pk(1, 2, 3, 4));
    send(1'b0, pk(9, 0, 0, 0));
    send(1'b0, pk(0, 0, 0, 5));
    send(1'b0, pk(0, 7, 0, 0));
    tests_run++; if (out_data !== pk(9, 7, 3, 5)) begin tests_failed++; $display("FAIL bp_first: got %h want %h", out_data, pk(9, 7, 3, 5)); end
    mode_i   = 1'b1;
    in_data  = pk(8, -4, 1, 100);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
      tests_run++; if (out_valid !== 1'b1 || out_data !== pk(9, 7, 3, 5)) begin tests_failed++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, pk(9, 7, 3, 5)); end
      tests_run++; if (win_cnt_o !== 2'd0) begin tests_failed++; $display("FAIL bp_cnt[%0d]: got %0d want 0", i, win_cnt_o); end
      idle_cycle();
    end
    out_ready = 1'b1;
    idle_cycle();
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || win_cnt_o !== 2'd1) begin tests_failed++; $display("FAIL bp_release: got valid %b cnt %0d want 0/1", out_valid, win_cnt_o); end
    send(1'b1, pk(8, -4, 2, 100));
    send(1'b1, pk(8, -4, 3, 100));
    send(1'b1, pk(8, -4, 4, 101));
    tests_run++; if (out_valid !== 1'b1 || out_data !== pk(8, -4, 2, 100)) begin tests_failed++; $display("FAIL bp_next: got %b/%h want 1/%h", out_valid, out_data, pk(8, -4, 2, 100)); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(1'b1, pk(4, -4, 1, 0));
    send(1'b0, pk(8, -8, 1, 0));
    send(1'b0, pk(0, 0, 1, 0));
    send(1'b0, pk(0, 0, 1, 3));
    tests_run++; if (out_valid !== 1'b1 || out_data !== pk(3, -3, 1, 0)) begin tests_failed++; $display("FAIL b2b_avg: got %b/%h want 1/%h", out_valid, out_data, pk(3, -3, 1, 0)); end
    send(1'b0, pk(1, -5, 6, -1));
    tests_run++; if (out_valid !== 1'b0 || win_cnt_o !== 2'd1) begin tests_failed++; $display("FAIL b2b_gap: got valid %b cnt %0d want 0/1", out_valid, win_cnt_o); end
    send(1'b1, pk(3, -6, 2, -1));
    send(1'b1, pk(2, -7, 9, -1));
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_mid: got %b want 0", out_valid); end
    send(1'b1, pk(0, -8, 4, -1));
    tests_run++; if (out_valid !== 1'b1 || out_data !== pk(3, -5, 9, -1)) begin tests_failed++; $display("FAIL b2b_max: got %b/%h want 1/%h", out_valid, out_data, pk(3, -5, 9, -1)); end
    idle_cycle();
  endtask

  task automatic test_clear_reset();
    send(1'b0, pk(1, 1, 1, 1));
    send(1'b0, pk(2, 2, 2, 2));
    tests_run++; if (win_cnt_o !== 2'd2) begin tests_failed++; $display("FAIL clr_pre: got %0d want 2", win_cnt_o); end
    clr_i = 1'b1;
    send(1'b0, pk(50, 50, 50, 50));
    clr_i = 1'b0;
    tests_run++; if (win_cnt_o !== 2'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_post: got cnt %0d valid %b want 0/0", win_cnt_o, out_valid); end
    out_ready = 1'b0;
    send(1'b0, pk(3, -3, 0, 0));
    send(1'b0, pk(1, -1, 0, 0));
    send(1'b0, pk(2, -2, 0, 0));
    send(1'b0, pk(0, -9, 0, 0));
    tests_run++; if (out_valid !== 1'b1 || out_data !== pk(3, -1, 0, 0)) begin tests_failed++; $display("FAIL clr_window: got %b/%h want 1/%h", out_valid, out_data, pk(3, -1, 0, 0)); end
    clr_i = 1'b1;
    idle_cycle();
    clr_i = 1'b0;
    tests_run++; if (out_valid !== 1'b1 || out_data !== pk(3, -1, 0, 0)) begin tests_failed++; $display("FAIL clr_keeps_result: got %b/%h want 1/%h", out_valid, out_data, pk(3, -1, 0, 0)); end
    out_ready = 1'b1;
    idle_cycle();
    for (int i = 0; i < 3; i++) send(1'b0, pk(7, 7, 7, 7));
    tests_run++; if (win_cnt_o !== 2'd3) begin tests_failed++; $display("FAIL rst_pre: got %0d want 3", win_cnt_o); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (win_cnt_o !== 2'd0 || out_valid !== 1'b0 || out_data !== 80'h0) begin tests_failed++; $display("FAIL rst_mid: got cnt %0d valid %b data %h want 0/0/0", win_cnt_o, out_valid, out_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();
    send(1'b0, pk(1, 0, 0, 0));
    send(1'b0, pk(0, 1, 0, 0));
    send(1'b0, pk(0, 0, 1, 0));
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_restart_early: got %b want 0", out_valid); end
    send(1'b0, pk(0, 0, 0, 1));
    tests_run++; if (out_valid !== 1'b1 || out_data !== pk(1, 1, 1, 1)) begin tests_failed++; $display("FAIL rst_restart: got %b/%h want 1/%h", out_valid, out_data, pk(1, 1, 1, 1)); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_max();
    test_avg();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_clear_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
